// File: rtl/mux_rr_reg.sv
// Multi-channel valid/ready multiplexer with fixed-select or round-robin arbitration,
// feeding one registered output stage that sustains one word per cycle.
module mux_rr_reg #(
   parameter int WIDTH = 32,
   parameter int N_IN  = 4,
   parameter int SEL_W = (N_IN > 2) ? $clog2(N_IN) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [N_IN-1:0]       in_valid,
   output logic [N_IN-1:0]       in_ready,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      select,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      out_idx
);

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] out_idx_q, out_idx_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   logic             load_en;
   logic             fix_hit;
   logic             rr_hit;
   logic             grant_valid;
   logic             take;
   logic [SEL_W-1:0] rr_gnt;
   logic [SEL_W-1:0] gnt;

   assign load_en = !out_valid_q || out_ready;
   assign fix_hit = (int'(select) < N_IN) && in_valid[select];

   // Search starts one past the last granted channel, so that channel ends up last in line.
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment, so no latch is inferred.
      rr_hit = 1'b0;
      rr_gnt = '0;
      for (int k = 1; k <= N_IN; k++) begin
         if (!rr_hit && in_valid[SEL_W'((int'(rr_ptr_q) + k) % N_IN)]) begin
            rr_hit = 1'b1;
            rr_gnt = SEL_W'((int'(rr_ptr_q) + k) % N_IN);
         end
      end
   end

   assign grant_valid = (mode == MODE_RR) ? rr_hit : fix_hit;
   assign gnt         = (mode == MODE_RR) ? rr_gnt : select;
   assign take        = grant_valid && load_en && !rst;

   always_comb begin
      in_ready = '0;
      if (take) in_ready[gnt] = 1'b1;
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q && !out_ready;
      rr_ptr_d    = rr_ptr_q;
      if (take) begin
         out_data_d  = in_data[gnt*WIDTH +: WIDTH];
         out_idx_d   = gnt;
         out_valid_d = 1'b1;
         if (mode == MODE_RR) rr_ptr_d = gnt;
      end
   end

   // Reset parks the pointer on the last channel so channel 0 wins the first round-robin grant.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         rr_ptr_q    <= SEL_W'(N_IN - 1);
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg: stimulus pushes expected words into a scoreboard,
// a monitor pops and compares on every output transfer.
module tb_mux_rr_reg;

   localparam int WIDTH = 32;
   localparam int N_IN  = 4;
   localparam int SEL_W = 2;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] idx;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N_IN*WIDTH-1:0] in_data;
   logic [N_IN-1:0]       in_valid;
   logic [N_IN-1:0]       in_ready;
   logic                  mode;
   logic [SEL_W-1:0]      select;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [SEL_W-1:0]      out_idx;

   exp_t sb[$];
   exp_t mon_e;
   int   n_pass  = 0;
   int   n_total = 0;

   mux_rr_reg #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .select    (select),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] word(input int ch);
      case (ch)
         0:       return 32'h1234_0000;
         1:       return 32'h5A5A_0001;
         2:       return 32'hAAAA_5555;
         default: return 32'hF00D_0003;
      endcase
   endfunction

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // One clock cycle: drive after the edge, check combinational ready and the
   // registered valid at the falling edge, then queue the word expected to transfer.
   task automatic cycle(input logic r, input logic m, input logic [SEL_W-1:0] sel,
                        input logic [N_IN-1:0] v, input logic rdy,
                        input logic [N_IN-1:0] exp_rdy, input int exp_ov);
      exp_t e;
      @(posedge clk);
      #1;
      rst       = r;
      mode      = m;
      select    = sel;
      in_valid  = v;
      out_ready = rdy;
      @(negedge clk);
      check("in_ready", WIDTH'(in_ready), WIDTH'(exp_rdy));
      check("out_valid", WIDTH'(out_valid), WIDTH'(exp_ov[0]));
      if (r) begin
         sb.delete();
      end else begin
         for (int g = 0; g < N_IN; g++) begin
            if (exp_rdy[g]) begin
               e.data = word(g);
               e.idx  = SEL_W'(g);
               sb.push_back(e);
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL sb_unexpected: got idx %0d data %0h, expected no word (t=%0t)",
                        out_idx, out_data, $time);
            end else begin
               mon_e = sb.pop_front();
               check("out_data", out_data, mon_e.data);
               check("out_idx", WIDTH'(out_idx), WIDTH'(mon_e.idx));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected end of run (t=%0t)", $time);
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      mode      = 1'b0;
      select    = '0;
      in_valid  = '0;
      out_ready = 1'b0;
      in_data   = {word(3), word(2), word(1), word(0)};

      // Reset: no grants while rst is high, outputs cleared.
      cycle(1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 0);
      cycle(1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 0);

      // Fixed select of channel 2, one-cycle latency.
      cycle(1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 0);
      check("reset_out_data", out_data, '0);
      check("reset_out_idx", WIDTH'(out_idx), '0);
      cycle(1'b0, 1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, 1);

      // Fixed select of a channel that is not offering: nothing granted.
      cycle(1'b0, 1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 0);
      cycle(1'b0, 1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 0);

      // Round-robin from the reset pointer: 0,1,2,3,0 back to back.
      for (int i = 0; i < 5; i++)
         cycle(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'(4'b0001 << (i % 4)), (i == 0) ? 0 : 1);

      // Back-pressure holds the word and blocks every input.
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1);
         check("stall_out_data", out_data, word(0));
         check("stall_out_idx", WIDTH'(out_idx), 32'd0);
      end
      cycle(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1);

      // Pointer at 1 with channels 1 and 3 offering: 3 then wrap to 1.
      cycle(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1);
      cycle(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1);
      cycle(1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1);

      // Reset while a word is held: word dropped, channel 0 first again.
      cycle(1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1);
      cycle(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 0);
      check("rst2_out_data", out_data, '0);
      check("rst2_out_idx", WIDTH'(out_idx), '0);
      cycle(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1);
      cycle(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 0);

      check("sb_drained", WIDTH'(sb.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mux_rr_reg.md
MUX_RR_REG -- requirements
Module: mux_rr_reg

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data width of each channel.
REQ-002 The block SHALL have parameter N_IN, default 4, meaning the number of input channels (legal range 2..16).
REQ-003 The block SHALL have derived parameter SEL_W, default clog2(N_IN) with a minimum of 1, meaning the select and index width.

Interface
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 in_data  input  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N_IN  channel i offers data.
REQ-008 in_ready  output  N_IN  channel i data accepted this cycle.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 select  input  SEL_W  channel index used in fixed mode.
REQ-011 out_data  output  WIDTH  registered output data.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_ready  input  1  downstream consumes the word this cycle.
REQ-014 out_idx  output  SEL_W  source channel of the word in out_data.

Function
REQ-015 A transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both 1 on a rising edge; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-016 load_en SHALL equal (!out_valid | out_ready); the output register SHALL accept a new word only when load_en is 1.
REQ-017 in_ready SHALL be combinational, one-hot or zero: in_ready[g] = load_en & grant_valid for the granted channel g; all other bits SHALL be 0.
REQ-018 In fixed mode: grant_valid = (select < N_IN) & in_valid[select], g = select; an out-of-range select SHALL grant nothing.
REQ-019 In round-robin mode: g SHALL be the first channel with in_valid = 1, searching from (rr_ptr+1) mod N_IN upward with wrap-around; grant_valid SHALL be 1 if any in_valid bit is 1.
REQ-020 On an input transfer: out_data <= in_data[g], out_idx <= g, out_valid <= 1; in round-robin mode rr_ptr <= g.
REQ-021 On an output transfer with no input transfer in the same cycle, out_valid SHALL go to 0; out_data and out_idx SHALL hold their values.
REQ-022 On a simultaneous output transfer and input transfer, the new word SHALL replace the old one with no bubble, giving a throughput of 1 word/cycle.
REQ-023 Latency SHALL be 1 cycle from an input transfer to out_valid = 1 carrying that word.
REQ-024 While out_valid = 1 and out_ready = 0, out_data, out_idx and out_valid SHALL be stable, and all in_ready bits SHALL be 0.
REQ-025 rr_ptr SHALL not change in fixed mode or in cycles with no input transfer.
REQ-026 A change of mode SHALL take effect in the same cycle for grant selection and SHALL not disturb a held word.
REQ-027 No data SHALL be lost or duplicated: each input transfer SHALL yield exactly one output transfer.

Reset
REQ-028 While rst = 1 at a rising edge: out_valid <= 0, out_data <= 0, out_idx <= 0, rr_ptr <= N_IN-1, so that channel 0 has first round-robin priority.
REQ-029 During a cycle with rst = 1, all in_ready bits SHALL be 0 and no input transfer SHALL occur.
REQ-030 Reset asserted mid-operation SHALL discard any held word; after reset the block SHALL behave as from power-up.

Verification (WIDTH=32, N_IN=4)
REQ-031 The bench SHALL check: fixed mode, select=2, in_valid=4'b0100, ch2=32'hAAAA5555, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hAAAA5555, out_idx=2.
REQ-032 The bench SHALL check: fixed mode, select=5 (out of range; SEL_W=3 for the test, or select driven to index 3 with in_valid[3]=0) -> in_ready=0 and out_valid stays 0.
REQ-033 The bench SHALL check: round-robin after reset with all in_valid=1 and out_ready=1 -> out_idx sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
REQ-034 The bench SHALL check: round-robin, out_ready=0 for 3 cycles while out_valid=1 -> out_data stable and in_ready=0 throughout; out_ready=1 -> next grant follows rr_ptr.
REQ-035 The bench SHALL check: in_valid=4'b1010 with rr_ptr=1 -> grant ch3, then ch1 (wrap-around skipping invalid channels).
REQ-036 The bench SHALL check: rst=1 while out_valid=1 -> next cycle out_valid=0, out_data=0, out_idx=0, and first round-robin grant goes to ch0.
